dcache_ctrl: RTL

- Data-side responder for the MEM stage. It accepts the request the EXE/MEM pipeline register drives: D_address, Dcache_en, Dcache_write, store data and funct3.
- It is a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache.
- It returns load data and raises Dstall while a miss or store is outstanding on a req/ack data-memory port.
- It must capture requests on their first cycle: the pipeline register clears Dcache_en after one stalled cycle but holds address, data and funct3.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_array.sv | 69 ++++++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Covers FSM states, access-size codes and store lane/strobe generation.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        RESP
    } state_e;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    // Unlisted sizes fall back to a full-word access.
    function automatic logic [3:0] gen_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Flop-based line storage: valid/tag/data per line.
// Provides a combinational read port and one byte-enabled write port.
module dcache_array #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             wr_set_valid
);
    localparam int NLINES = 2 ** IDX_W;

    logic [NLINES-1:0]            valid_all;
    logic [NLINES-1:0][TAG_W-1:0] tag_all;
    logic [NLINES-1:0][31:0]      data_all;

    for (genvar i = 0; i < NLINES; i++) begin : g_line
        logic             line_we;
        logic             valid_q, valid_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic [31:0]      data_q, data_d;

        assign line_we = we && (wr_idx == IDX_W'(i));

        // Tag only moves on a fill; store merges keep the resident tag.
        always_comb begin
            valid_d = valid_q;
            tag_d   = tag_q;
            data_d  = data_q;
            if (line_we) begin
                if (wr_set_valid) begin
                    valid_d = 1'b1;
                    tag_d   = wr_tag;
                end
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) data_d[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) valid_q <= 1'b0;
            else      valid_q <= valid_d;
        end

        always_ff @(posedge clk) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end

        assign valid_all[i] = valid_q;
        assign tag_all[i]   = tag_q;
        assign data_all[i]  = data_q;
    end

    assign rd_valid = valid_all[rd_idx];
    assign rd_tag   = tag_all[rd_idx];
    assign rd_data  = data_all[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, one word per line,
// write-through, no-write-allocate, with a req/ack backing-memory port.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Dcache_en,
    input  logic              Dcache_write,
    input  logic [ADDR_W-1:0] D_address,
    input  logic [31:0]       D_in,
    input  logic [2:0]        funct3_EXE_MEM,
    output logic [31:0]       D_out,
    output logic              Dstall,
    output logic              DM_req,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_addr,
    output logic [31:0]       DM_wdata,
    output logic [3:0]        DM_wstrb,
    input  logic              DM_ack,
    input  logic [31:0]       DM_rdata
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    state_e            state_q, state_d;
    logic [WA_W-1:0]   req_addr_q, req_addr_d;
    logic [31:0]       hold_q, hold_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_write_q, dm_write_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [3:0]        dm_wstrb_q, dm_wstrb_d;

    logic [WA_W-1:0]   cur_addr;
    logic              rd_valid, hit;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              arr_we, arr_set_valid;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;

    // Lookup uses the live request in IDLE and the captured one afterwards,
    // since the pipeline drops Dcache_en after the first stalled cycle.
    assign cur_addr = (state_q == IDLE) ? D_address[ADDR_W-1:2] : req_addr_q;
    assign hit      = rd_valid && (rd_tag == cur_addr[WA_W-1:IDX_W]);

    dcache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (cur_addr[IDX_W-1:0]),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .we           (arr_we),
        .wr_idx       (req_addr_q[IDX_W-1:0]),
        .wr_tag       (req_addr_q[WA_W-1:IDX_W]),
        .wr_be        (arr_be),
        .wr_data      (arr_wdata),
        .wr_set_valid (arr_set_valid)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        hold_d        = hold_q;
        dm_req_d      = dm_req_q;
        dm_write_d    = dm_write_q;
        dm_wdata_d    = dm_wdata_q;
        dm_wstrb_d    = dm_wstrb_q;
        arr_we        = 1'b0;
        arr_set_valid = 1'b0;
        arr_be        = 4'b0000;
        arr_wdata     = 32'h0;
        Dstall        = 1'b0;
        D_out         = hold_q;

        case (state_q)
            IDLE: begin
                if (Dcache_en) begin
                    if (!Dcache_write && hit) begin
                        D_out  = rd_data;
                        hold_d = rd_data;
                    end else begin
                        Dstall     = 1'b1;
                        req_addr_d = D_address[ADDR_W-1:2];
                        dm_req_d   = 1'b1;
                        dm_write_d = Dcache_write;
                        dm_wdata_d = Dcache_write ? rep_wdata(funct3_EXE_MEM, D_in) : 32'h0;
                        dm_wstrb_d = Dcache_write ? gen_wstrb(funct3_EXE_MEM, D_address[1:0]) : 4'b0000;
                        state_d    = Dcache_write ? WR_THRU : RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                Dstall = 1'b1;
                if (DM_ack) begin
                    arr_we        = 1'b1;
                    arr_set_valid = 1'b1;
                    arr_be        = 4'b1111;
                    arr_wdata     = DM_rdata;
                    hold_d        = DM_rdata;
                    dm_req_d      = 1'b0;
                    state_d       = RESP;
                end
            end
            WR_THRU: begin
                Dstall = 1'b1;
                if (DM_ack) begin
                    // No allocation: only a resident line absorbs the store.
                    arr_we    = hit;
                    arr_be    = dm_wstrb_q;
                    arr_wdata = dm_wdata_q;
                    dm_req_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            hold_q     <= 32'h0;
            dm_req_q   <= 1'b0;
            dm_write_q <= 1'b0;
            dm_wdata_q <= 32'h0;
            dm_wstrb_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
            dm_req_q   <= dm_req_d;
            dm_write_q <= dm_write_d;
            dm_wdata_q <= dm_wdata_d;
            dm_wstrb_q <= dm_wstrb_d;
        end
    end

    assign DM_req   = dm_req_q;
    assign DM_write = dm_write_q;
    assign DM_addr  = {req_addr_q, 2'b00};
    assign DM_wdata = dm_wdata_q;
    assign DM_wstrb = dm_wstrb_q;

endmodule
